// File: rtl/sync_prefetch_fifo_ctl.sv
// sync_prefetch_fifo_ctl
// Single-clock first-word-fall-through FIFO. The head entry is always presented
// on a registered rd_data port. The storage array holds every entry, including
// the head, so the capacity is exactly DEPTH words. The block provides a live
// occupancy count, almost-full/almost-empty flags, a flush input and sticky
// overflow/underflow error flags.
module sync_prefetch_fifo_ctl #(
    parameter int DATA_WIDTH  = 10,
    parameter int DEPTH_WIDTH = 5,
    parameter int AF_THRESH   = (2 ** DEPTH_WIDTH) - 2,
    parameter int AE_THRESH   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    output logic                   wr_vld,
    input  logic                   rd_en,
    output logic                   rd_vld,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic [DEPTH_WIDTH:0]   count,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int DEPTH = 2 ** DEPTH_WIDTH;

    typedef logic [DEPTH_WIDTH:0]   count_t;
    typedef logic [DEPTH_WIDTH-1:0] ptr_t;

    localparam count_t DEPTH_CNT = count_t'(DEPTH);
    localparam count_t AF_CNT    = count_t'(AF_THRESH);
    localparam count_t AE_CNT    = count_t'(AE_THRESH);
    localparam count_t ONE_CNT   = count_t'(1);
    localparam ptr_t   ONE_PTR   = ptr_t'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    ptr_t                  wr_ptr;
    ptr_t                  rd_ptr;
    ptr_t                  rd_ptr_inc;
    count_t                count_next;
    logic                  wr_accept;
    logic                  rd_accept;
    logic                  head_load;
    logic [DATA_WIDTH-1:0] head_next;

    // Space is judged from the registered count only, so a same-cycle read never frees a slot early.
    assign wr_vld     = (count != DEPTH_CNT);
    assign wr_accept  = wr_en && wr_vld && !flush;
    assign rd_accept  = rd_en && rd_vld && !flush;
    assign rd_ptr_inc = rd_ptr + ONE_PTR;

    // Occupancy after this edge, from which every status flag is derived.
    always_comb begin
        count_next = count;
        case ({wr_accept, rd_accept})
            2'b10:   count_next = count + ONE_CNT;
            2'b01:   count_next = count - ONE_CNT;
            default: count_next = count;
        endcase
    end

    // Choose the next head word: the following array entry after a pop, or bypass wr_data when the new word becomes head.
    always_comb begin
        head_load = 1'b0;
        head_next = rd_data;
        if (rd_accept) begin
            if (count > ONE_CNT) begin
                head_load = 1'b1;
                head_next = mem[rd_ptr_inc];
            end else if (wr_accept) begin
                head_load = 1'b1;
                head_next = wr_data;
            end
        end else if (wr_accept && (count == '0)) begin
            head_load = 1'b1;
            head_next = wr_data;
        end
    end

    // Storage array, written on every accepted write and never reset.
    always_ff @(posedge clk) begin
        if (rst_n && wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, count, head register and flags. Reset takes priority over flush, and flush takes priority over traffic.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rd_vld       <= 1'b0;
            rd_data      <= '0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rd_vld       <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + ONE_PTR;
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr_inc;
            end
            if (head_load) begin
                rd_data <= head_next;
            end
            count        <= count_next;
            rd_vld       <= (count_next != '0);
            almost_full  <= (count_next >= AF_CNT);
            almost_empty <= (count_next <= AE_CNT);
            overflow     <= overflow  | (wr_en && !wr_vld);
            underflow    <= underflow | (rd_en && !rd_vld);
        end
    end

endmodule

// File: tb/tb_sync_prefetch_fifo_ctl.sv
// tb_sync_prefetch_fifo_ctl
// Self-checking bench with two instances. The first uses the default parameters
// (DEPTH 32) and is driven by a vector table followed by hand-written corner
// sequences. The second uses DEPTH_WIDTH 2 (DEPTH 4) and is driven by random
// traffic that is compared against a queue-based reference model.
module tb_sync_prefetch_fifo_ctl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance signals
    logic       rst_n, flush, wr_en, rd_en;
    logic [9:0] wr_data;
    logic       wr_vld, rd_vld, almost_full, almost_empty, overflow, underflow;
    logic [9:0] rd_data;
    logic [5:0] count;

    // Small instance signals
    logic       s_rst_n, s_flush, s_wr_en, s_rd_en;
    logic [9:0] s_wr_data;
    logic       s_wr_vld, s_rd_vld, s_af, s_ae, s_ovf, s_unf;
    logic [9:0] s_rd_data;
    logic [2:0] s_count;

    int checks = 0;
    int passes = 0;

    sync_prefetch_fifo_ctl dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_en(wr_en), .wr_data(wr_data), .wr_vld(wr_vld),
        .rd_en(rd_en), .rd_vld(rd_vld), .rd_data(rd_data),
        .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    sync_prefetch_fifo_ctl #(.DATA_WIDTH(10), .DEPTH_WIDTH(2)) dut_small (
        .clk(clk), .rst_n(s_rst_n), .flush(s_flush),
        .wr_en(s_wr_en), .wr_data(s_wr_data), .wr_vld(s_wr_vld),
        .rd_en(s_rd_en), .rd_vld(s_rd_vld), .rd_data(s_rd_data),
        .count(s_count), .almost_full(s_af), .almost_empty(s_ae),
        .overflow(s_ovf), .underflow(s_unf)
    );

    typedef struct {
        logic       rst_n;
        logic       flush;
        logic       wr_en;
        logic [9:0] wr_data;
        logic       rd_en;
        logic       exp_wr_vld;
        logic       exp_rd_vld;
        logic [9:0] exp_rd_data;
        logic [5:0] exp_count;
        logic       exp_af;
        logic       exp_ae;
        logic       exp_ovf;
        logic       exp_unf;
    } vec_t;

    vec_t vecs [13];

    // Reference model for the small instance
    logic [9:0] mq [$];
    logic [9:0] mhead;
    logic       movf, munf;

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic f, input logic w, input logic [9:0] d, input logic rd);
        rst_n   = r;
        flush   = f;
        wr_en   = w;
        wr_data = d;
        rd_en   = rd;
        stepClock();
    endtask

    task automatic checkSmall(input string tag);
        int sz;
        sz = mq.size();
        checkOutput({tag, ".count"}, 32'(s_count), 32'(sz));
        checkOutput({tag, ".rd_vld"}, 32'(s_rd_vld), 32'(sz != 0));
        checkOutput({tag, ".rd_data"}, 32'(s_rd_data), 32'(mhead));
        checkOutput({tag, ".wr_vld"}, 32'(s_wr_vld), 32'(sz < 4));
        checkOutput({tag, ".almost_full"}, 32'(s_af), 32'(sz >= 2));
        checkOutput({tag, ".almost_empty"}, 32'(s_ae), 32'(sz <= 1));
        checkOutput({tag, ".overflow"}, 32'(s_ovf), 32'(movf));
        checkOutput({tag, ".underflow"}, 32'(s_unf), 32'(munf));
    endtask

    initial begin
        logic [9:0] w;
        int         exp_cnt;

        rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        s_rst_n = 1'b0; s_flush = 1'b0; s_wr_en = 1'b0; s_rd_en = 1'b0; s_wr_data = '0;

        //                rst   fl    wr    data     rd    wrv   rdv   rdata    cnt    af    ae    ovf   unf
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h000, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 10'h000, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 10'h0AA, 1'b0, 1'b1, 1'b1, 10'h0AA, 6'd1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 10'h055, 1'b0, 1'b1, 1'b1, 10'h0AA, 6'd2, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 10'h123, 1'b1, 1'b1, 1'b1, 10'h055, 6'd2, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 1'b1, 10'h123, 6'd1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 10'h123, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 10'h123, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 10'h2AA, 1'b1, 1'b1, 1'b0, 10'h123, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 10'h3FF, 1'b0, 1'b1, 1'b1, 10'h3FF, 6'd1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 10'h001, 1'b1, 1'b1, 1'b1, 10'h001, 6'd1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 10'h001, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 10'h0CC, 1'b0, 1'b1, 1'b0, 10'h000, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0};

        $display("[TB] vector table");
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].rst_n, vecs[i].flush, vecs[i].wr_en, vecs[i].wr_data, vecs[i].rd_en);
            checkOutput($sformatf("vec%0d.wr_vld", i), 32'(wr_vld), 32'(vecs[i].exp_wr_vld));
            checkOutput($sformatf("vec%0d.rd_vld", i), 32'(rd_vld), 32'(vecs[i].exp_rd_vld));
            checkOutput($sformatf("vec%0d.rd_data", i), 32'(rd_data), 32'(vecs[i].exp_rd_data));
            checkOutput($sformatf("vec%0d.count", i), 32'(count), 32'(vecs[i].exp_count));
            checkOutput($sformatf("vec%0d.almost_full", i), 32'(almost_full), 32'(vecs[i].exp_af));
            checkOutput($sformatf("vec%0d.almost_empty", i), 32'(almost_empty), 32'(vecs[i].exp_ae));
            checkOutput($sformatf("vec%0d.overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
            checkOutput($sformatf("vec%0d.underflow", i), 32'(underflow), 32'(vecs[i].exp_unf));
        end

        $display("[TB] fill to full");
        for (int i = 1; i <= 32; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 10'(i), 1'b0);
            checkOutput($sformatf("fill%0d.count", i), 32'(count), 32'(i));
            checkOutput($sformatf("fill%0d.rd_vld", i), 32'(rd_vld), 32'(1));
            checkOutput($sformatf("fill%0d.rd_data", i), 32'(rd_data), 32'(1));
            checkOutput($sformatf("fill%0d.almost_full", i), 32'(almost_full), 32'(i >= 30));
            checkOutput($sformatf("fill%0d.wr_vld", i), 32'(wr_vld), 32'(i < 32));
        end

        $display("[TB] overflow on full");
        applyStimulus(1'b1, 1'b0, 1'b1, 10'h3FF, 1'b0);
        checkOutput("ovf.count", 32'(count), 32'(32));
        checkOutput("ovf.overflow", 32'(overflow), 32'(1));
        checkOutput("ovf.rd_data", 32'(rd_data), 32'(1));

        $display("[TB] drain");
        for (int i = 1; i <= 32; i++) begin
            checkOutput($sformatf("drain%0d.head", i), 32'(rd_data), 32'(i));
            applyStimulus(1'b1, 1'b0, 1'b0, 10'h000, 1'b1);
            exp_cnt = 32 - i;
            checkOutput($sformatf("drain%0d.count", i), 32'(count), 32'(exp_cnt));
            checkOutput($sformatf("drain%0d.rd_vld", i), 32'(rd_vld), 32'(exp_cnt != 0));
            checkOutput($sformatf("drain%0d.almost_empty", i), 32'(almost_empty), 32'(exp_cnt <= 1));
            checkOutput($sformatf("drain%0d.overflow", i), 32'(overflow), 32'(1));
        end
        checkOutput("drain.rd_data_hold", 32'(rd_data), 32'(32));

        $display("[TB] underflow on empty");
        applyStimulus(1'b1, 1'b0, 1'b0, 10'h000, 1'b1);
        checkOutput("unf.underflow", 32'(underflow), 32'(1));
        checkOutput("unf.rd_data", 32'(rd_data), 32'(32));
        checkOutput("unf.count", 32'(count), 32'(0));

        $display("[TB] streaming at count 1");
        applyStimulus(1'b1, 1'b0, 1'b1, 10'h155, 1'b0);
        checkOutput("stream.first", 32'(rd_data), 32'(10'h155));
        for (int k = 0; k < 100; k++) begin
            w = 10'h155 ^ 10'(k + 1);
            applyStimulus(1'b1, 1'b0, 1'b1, w, 1'b1);
            checkOutput($sformatf("stream%0d.count", k), 32'(count), 32'(1));
            checkOutput($sformatf("stream%0d.rd_data", k), 32'(rd_data), 32'(w));
        end

        $display("[TB] flush at count 20");
        for (int i = 0; i < 19; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 10'(i + 200), 1'b0);
        end
        checkOutput("flush.pre_count", 32'(count), 32'(20));
        applyStimulus(1'b1, 1'b1, 1'b1, 10'h2F0, 1'b1);
        checkOutput("flush.count", 32'(count), 32'(0));
        checkOutput("flush.rd_vld", 32'(rd_vld), 32'(0));
        checkOutput("flush.wr_vld", 32'(wr_vld), 32'(1));
        checkOutput("flush.overflow", 32'(overflow), 32'(0));
        checkOutput("flush.underflow", 32'(underflow), 32'(0));
        checkOutput("flush.almost_empty", 32'(almost_empty), 32'(1));
        checkOutput("flush.almost_full", 32'(almost_full), 32'(0));
        applyStimulus(1'b1, 1'b0, 1'b1, 10'h0BB, 1'b0);
        checkOutput("flush.post_data", 32'(rd_data), 32'(10'h0BB));
        checkOutput("flush.post_count", 32'(count), 32'(1));
        applyStimulus(1'b1, 1'b0, 1'b0, 10'h000, 1'b0);

        $display("[TB] random traffic at depth 4");
        s_rst_n = 1'b0;
        stepClock();
        mq.delete();
        mhead = '0; movf = 1'b0; munf = 1'b0;
        checkSmall("sreset");
        s_rst_n = 1'b1;
        for (int n = 0; n < 80; n++) begin
            logic full, empty;
            s_wr_en   = ($urandom_range(0, 99) < 55);
            s_rd_en   = ($urandom_range(0, 99) < 50);
            s_flush   = ($urandom_range(0, 39) == 0);
            s_wr_data = 10'($urandom);
            if (s_flush) begin
                mq.delete();
                movf = 1'b0;
                munf = 1'b0;
            end else begin
                full  = (mq.size() == 4);
                empty = (mq.size() == 0);
                if (s_wr_en && full)  movf = 1'b1;
                if (s_rd_en && empty) munf = 1'b1;
                if (s_rd_en && !empty) void'(mq.pop_front());
                if (s_wr_en && !full)  mq.push_back(s_wr_data);
            end
            if (mq.size() != 0) mhead = mq[0];
            stepClock();
            checkSmall($sformatf("rnd%0d", n));
        end

        $display("[TB] reset mid-stream");
        s_flush = 1'b0; s_rd_en = 1'b0; s_wr_en = 1'b1; s_wr_data = 10'h1E1;
        stepClock();
        s_rst_n = 1'b0; s_wr_data = 10'h2E2;
        stepClock();
        mq.delete();
        mhead = '0; movf = 1'b0; munf = 1'b0;
        checkSmall("midreset");
        s_rst_n = 1'b1; s_wr_en = 1'b0;
        stepClock();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
